// File: rtl/booth_mul_ctrl_if.sv
// Handshake and multiplier-side bus for booth_mul_ctrl.
// Optional macro: BOOTH_MUL_OVF_EN adds the out_ovf flag.
interface booth_mul_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_sel;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [WIDTH-1:0]   out_word;
  logic               busy;
`ifdef BOOTH_MUL_OVF_EN
  logic               out_ovf;
`endif

  // Environment side: issues operands, models the multiplier, consumes results.
  modport master (
    output in_valid, in_a, in_b, in_sel, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_product, out_word, busy
`ifdef BOOTH_MUL_OVF_EN
    , input out_ovf
`endif
  );

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, in_sel, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_product, out_word, busy
`ifdef BOOTH_MUL_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Issue/capture stage around the combinational signed booth_mul array.
// Operands are registered onto the multiplier, a multicycle settle window is
// counted out, then the product is captured and handed to writeback.
// Optional macro: BOOTH_MUL_OVF_EN registers a signed-WIDTH overflow flag.
module booth_mul_ctrl #(
  parameter int WIDTH     = 32,
  parameter int MC_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  booth_mul_ctrl_if.slave bus
);

  localparam int McEff = (MC_CYCLES < 1) ? 1 : MC_CYCLES;
  localparam int CntW  = $clog2(McEff) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
`ifdef BOOTH_MUL_OVF_EN
  logic               ovf_q, ovf_d;
  logic [WIDTH:0]     prod_top;

  // Product fits signed WIDTH bits only if the sign bit and everything above agree.
  assign prod_top = bus.mul_p[2*WIDTH-1:WIDTH-1];
`endif

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
`ifdef BOOTH_MUL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q  <= prod_d;
`ifdef BOOTH_MUL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state: accept in IDLE, count down the settle window, hold until consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    prod_d  = prod_q;
`ifdef BOOTH_MUL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          sel_d   = bus.in_sel;
          cnt_d   = CntW'(McEff - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          prod_d  = bus.mul_p;
`ifdef BOOTH_MUL_OVF_EN
          ovf_d   = !((&prod_top) || !(|prod_top));
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.out_product = prod_q;
  assign bus.out_word    = sel_q ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
`ifdef BOOTH_MUL_OVF_EN
  assign bus.out_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed scoreboard bench for booth_mul_ctrl (MC_CYCLES=2 and MC_CYCLES=4 instances).
module tb_booth_mul_ctrl;

  logic clk;
  logic rst_n;

  booth_mul_ctrl_if #(.WIDTH(32)) bus ();
  booth_mul_ctrl_if #(.WIDTH(32)) bus4 ();

  booth_mul_ctrl #(.WIDTH(32), .MC_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  booth_mul_ctrl #(.WIDTH(32), .MC_CYCLES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Behavioural stand-in for the combinational signed booth_mul array.
  assign bus.mul_p  = $signed({{32{bus.mul_a[31]}}, bus.mul_a}) *
                      $signed({{32{bus.mul_b[31]}}, bus.mul_b});
  assign bus4.mul_p = $signed({{32{bus4.mul_a[31]}}, bus4.mul_a}) *
                      $signed({{32{bus4.mul_b[31]}}, bus4.mul_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    logic [31:0] word;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op, wait (bounded) for acceptance, optionally record the expected result.
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic sel,
                           input logic [63:0] prod, input bit push);
    int   w;
    exp_t e;
    logic [32:0] top;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept_bound", 64'(w < 50), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push) begin
      top    = prod[63:31];
      e.prod = prod;
      e.word = sel ? prod[63:32] : prod[31:0];
      e.ovf  = !((&top) || !(|top));
      sb_q.push_back(e);
    end
  endtask

  // Count edges from acceptance until out_valid rises.
  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  // Compare the presented result against the scoreboard and complete the handshake.
  task automatic drain();
    exp_t e;
    check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("out_valid", 64'(bus.out_valid), 64'd1);
      check("out_product", bus.out_product, e.prod);
      check("out_word", 64'(bus.out_word), 64'(e.word));
`ifdef BOOTH_MUL_OVF_EN
      check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
`endif
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", 64'(bus.out_valid), 64'd0);
    check("ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_a      = '0;
    bus4.in_b      = '0;
    bus4.in_sel    = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_product", bus.out_product, 64'd0);
    check("rst_word", 64'(bus.out_word), 64'd0);
    check("rst_mul_a", 64'(bus.mul_a), 64'd0);
    check("rst_mul_b", 64'(bus.mul_b), 64'd0);
`ifdef BOOTH_MUL_OVF_EN
    check("rst_ovf", 64'(bus.out_ovf), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic signed products and word select
    accept_op(32'd20, 32'hFFFFFFFD, 1'b0, 64'hFFFFFFFFFFFFFFC4, 1'b1);
    check("wait_busy", 64'(bus.busy), 64'd1);
    check("wait_in_ready", 64'(bus.in_ready), 64'd0);
    wait_valid(2);
    drain();
    accept_op(32'hFFFFFFA6, 32'hFFFFFFA6, 1'b1, 64'h0000000000001FA4, 1'b1);
    wait_valid(2);
    drain();
    accept_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
    wait_valid(2);
    drain();
    accept_op(32'h7FFFFFFF, 32'd2, 1'b0, 64'h00000000FFFFFFFE, 1'b1);
    wait_valid(2);
    drain();
    accept_op(32'd1, 32'd98765, 1'b0, 64'd98765, 1'b1);
    wait_valid(2);
    drain();

    // Backpressure: result held, competing request ignored until consumed
    bus.out_ready = 1'b0;
    accept_op(32'hFFFFFF38, 32'd4008, 1'b0, 64'hFFFFFFFFFFF3C4C0, 1'b1);
    bus.in_a     = 32'd7;
    bus.in_b     = 32'd7;
    bus.in_valid = 1'b1;
    wait_valid(2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_product", bus.out_product, 64'hFFFFFFFFFFF3C4C0);
      check("bp_word", 64'(bus.out_word), 64'hFFF3C4C0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_mul_a", 64'(bus.mul_a), 64'hFFFFFF38);
      @(posedge clk); #1;
    end
    drain();
    accept_op(32'd7, 32'd7, 1'b0, 64'd49, 1'b1);
    wait_valid(2);
    drain();

    // Reset during WAIT aborts the op
    accept_op(32'd77, 32'd88, 1'b0, 64'd6776, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_mul_a", 64'(bus.mul_a), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy_rel", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    accept_op(32'd0, 32'd98765, 1'b0, 64'd0, 1'b1);
    wait_valid(2);
    drain();

    // MC_CYCLES=4 instance
    bus4.in_a     = 32'hFFFFFF91;
    bus4.in_b     = 32'hFFFFF752;
    bus4.in_valid = 1'b1;
    check("mc4_in_ready", 64'(bus4.in_ready), 64'd1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("mc4_latency", 64'(lat), 64'd4);
    check("mc4_product", bus4.out_product, 64'd246642);
    check("mc4_word", 64'(bus4.out_word), 64'd246642);
`ifdef BOOTH_MUL_OVF_EN
    check("mc4_ovf", 64'(bus4.out_ovf), 64'd0);
`endif
    @(posedge clk); #1;
    check("mc4_valid_drop", 64'(bus4.out_valid), 64'd0);

    check("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
